// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
//
// Drives a common-anode 4-digit 7-segment display from the four BCD digits of
// the cascaded counter chain. Once per frame (the last clock of slot 3), the
// four digits and their decimal-point enables are copied into shadow
// registers. The display therefore never shows a half-rippled carry from the
// counter chain. The shadow digits are then scanned one slot at a time.
//
// Each slot lasts SCAN_DIV clocks. The first BLANK_CYC clocks of a slot keep
// every digit dark, so the previous digit's segments are not seen on the next
// digit (anti-ghosting).
//
// Parameters:
//   SCAN_DIV   clocks per digit slot (>= 2)
//   BLANK_CYC  dark clocks at the start of each slot (0 <= BLANK_CYC < SCAN_DIV)
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   seg0_dig    least-significant BCD digit
//   seg1_dig    BCD digit 1
//   seg2_dig    BCD digit 2
//   seg3_dig    most-significant BCD digit
//   dp_en       decimal-point enable per digit (bit i = digit i)
//   blank_lz    1 = suppress leading zeros (used live, not snapshotted)
//   dig_sel     active-low digit enables (bit i = digit i)
//   seg_out     active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick  one-clock pulse when the shadow registers load
// -----------------------------------------------------------------------------
module seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] seg0_dig,
    input  logic [3:0] seg1_dig,
    input  logic [3:0] seg2_dig,
    input  logic [3:0] seg3_dig,
    input  logic [3:0] dp_en,
    input  logic       blank_lz,
    output logic [3:0] dig_sel,
    output logic [7:0] seg_out,
    output logic       frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    // Active-high {g,f,e,d,c,b,a}. Codes 10-15 are not BCD, so they show a
    // dash. This tells the viewer that the counter chain produced an invalid
    // digit.
    function automatic logic [6:0] decode7(input logic [3:0] code);
        logic [6:0] segs;
        case (code)
            4'd0:    segs = 7'h3F;
            4'd1:    segs = 7'h06;
            4'd2:    segs = 7'h5B;
            4'd3:    segs = 7'h4F;
            4'd4:    segs = 7'h66;
            4'd5:    segs = 7'h6D;
            4'd6:    segs = 7'h7D;
            4'd7:    segs = 7'h07;
            4'd8:    segs = 7'h7F;
            4'd9:    segs = 7'h6F;
            default: segs = 7'h40;
        endcase
        return segs;
    endfunction

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       slot_reg;
    logic [3:0]       sh_reg [4];
    logic [3:0]       dp_sh_reg;
    logic [3:0]       dig_sel_reg;
    logic [7:0]       seg_out_reg;
    logic             frame_tick_reg;

    logic [3:0]       dig_in [4];
    logic [7:0]       seg_code [4];
    logic [3:0]       blank;
    logic             slot_end;
    logic             frame_boundary;
    logic [3:0]       dig_sel_next;
    logic [7:0]       seg_out_next;

    assign dig_in[0] = seg0_dig;
    assign dig_in[1] = seg1_dig;
    assign dig_in[2] = seg2_dig;
    assign dig_in[3] = seg3_dig;

    assign slot_end       = (cnt_reg == CNT_LAST);
    assign frame_boundary = slot_end && (slot_reg == 2'd3);

    // Prescaler and slot counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            slot_reg <= 2'd0;
        end else if (slot_end) begin
            cnt_reg  <= '0;
            slot_reg <= slot_reg + 2'd1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    // Frame snapshot. This is the only point where the display accepts new
    // digit and decimal-point values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                sh_reg[i] <= 4'd0;
            end
            dp_sh_reg <= 4'd0;
        end else if (frame_boundary) begin
            for (int i = 0; i < 4; i++) begin
                sh_reg[i] <= dig_in[i];
            end
            dp_sh_reg <= dp_en;
        end
    end

    // Active-high segment pattern per digit, including its decimal point.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_code
            assign seg_code[gi] = {dp_sh_reg[gi], decode7(sh_reg[gi])};
        end
    endgenerate

    // Leading-zero suppression works from the most significant digit downward.
    // Digit 0 always shows, so a value of zero still displays "0".
    assign blank[3] = blank_lz && (sh_reg[3] == 4'd0);
    assign blank[2] = blank[3] && (sh_reg[2] == 4'd0);
    assign blank[1] = blank[2] && (sh_reg[1] == 4'd0);
    assign blank[0] = 1'b0;

    // A blanked digit is fully dark, including its decimal point.
    always_comb begin
        dig_sel_next = 4'hF;
        seg_out_next = 8'hFF;
        if ((cnt_reg >= BLANK_LIM) && !blank[slot_reg]) begin
            dig_sel_next = ~(4'b0001 << slot_reg);
            seg_out_next = ~seg_code[slot_reg];
        end
    end

    // Pin drivers are registered so the board sees glitch-free outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            dig_sel_reg    <= 4'hF;
            seg_out_reg    <= 8'hFF;
            frame_tick_reg <= 1'b0;
        end else begin
            dig_sel_reg    <= dig_sel_next;
            seg_out_reg    <= seg_out_next;
            frame_tick_reg <= frame_boundary;
        end
    end

    assign dig_sel    = dig_sel_reg;
    assign seg_out    = seg_out_reg;
    assign frame_tick = frame_tick_reg;

endmodule
